// File: rtl/spike_count_readout.sv
// spike_count_readout: counts output-layer spikes over a window of timesteps,
// then scans the per-neuron counts and reports the winning class via valid/ack.
//
// Ports:
//   clk, reset   clock; asynchronous active-high reset
//   start        begin a window (accepted only when idle)
//   window_len   timesteps per window, sampled with start (0 acts as 1)
//   ce           timestep strobe, spikes sampled when ce=1 while accumulating
//   spikes       one spike bit per output neuron
//   ack          consumer acknowledges the result
//   busy         accumulating or scanning
//   class_valid  result available, held until ack
//   class_id     index of the winning neuron (lowest index on ties)
//   class_count  spike count of the winner
//   tie          another neuron matched the winning count
module spike_count_readout #(
  parameter int N_OUT       = 10,
  parameter int COUNT_BITS  = 8,
  parameter int WINDOW_BITS = 8,
  parameter int ID_BITS     = $clog2(N_OUT)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [WINDOW_BITS-1:0] window_len,
  input  logic                   ce,
  input  logic [N_OUT-1:0]       spikes,
  input  logic                   ack,
  output logic                   busy,
  output logic                   class_valid,
  output logic [ID_BITS-1:0]     class_id,
  output logic [COUNT_BITS-1:0]  class_count,
  output logic                   tie
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_SCAN,
    S_DONE
  } state_e;

  localparam logic [COUNT_BITS-1:0] CNT_MAX =
    {COUNT_BITS{1'b1}};
  localparam logic [ID_BITS-1:0] LAST_IDX =
    ID_BITS'(N_OUT - 1);
  localparam logic [WINDOW_BITS-1:0] ONE_STEP =
    WINDOW_BITS'(1);

  state_e                  state_q, state_d;
  logic [COUNT_BITS-1:0]   cnt_q [N_OUT];
  logic [COUNT_BITS-1:0]   cnt_d [N_OUT];
  logic [WINDOW_BITS-1:0]  step_q, step_d;
  logic [WINDOW_BITS-1:0]  len_q, len_d;
  logic [ID_BITS-1:0]      scan_idx_q, scan_idx_d;
  logic [COUNT_BITS-1:0]   best_q, best_d;
  logic [ID_BITS-1:0]      best_id_q, best_id_d;
  logic                    scan_tie_q, scan_tie_d;
  logic [ID_BITS-1:0]      class_id_q, class_id_d;
  logic [COUNT_BITS-1:0]   class_count_q;
  logic [COUNT_BITS-1:0]   class_count_d;
  logic                    tie_q, tie_d;
  logic                    busy_q, busy_d;
  logic                    valid_q, valid_d;
  logic [COUNT_BITS-1:0]   scan_val;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    step_d        = step_q;
    len_d         = len_q;
    scan_idx_d    = scan_idx_q;
    best_d        = best_q;
    best_id_d     = best_id_q;
    scan_tie_d    = scan_tie_q;
    class_id_d    = class_id_q;
    class_count_d = class_count_q;
    tie_d         = tie_q;
    scan_val      = cnt_q[scan_idx_q];

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ACCUM;
          step_d  = '0;
          for (int i = 0; i < N_OUT; i++) begin
            cnt_d[i] = '0;
          end
          len_d = (window_len == '0) ? ONE_STEP
                                     : window_len;
        end
      end

      S_ACCUM: begin
        if (ce) begin
          for (int i = 0; i < N_OUT; i++) begin
            if (spikes[i] && cnt_q[i] != CNT_MAX) begin
              cnt_d[i] = cnt_q[i] + 1'b1;
            end
          end
          step_d = step_q + 1'b1;
          if (step_d == len_q) begin
            state_d    = S_SCAN;
            scan_idx_d = '0;
          end
        end
      end

      S_SCAN: begin
        // Strict greater-than keeps the lowest index on equal counts.
        if (scan_idx_q == '0) begin
          best_d     = scan_val;
          best_id_d  = '0;
          scan_tie_d = 1'b0;
        end else if (scan_val > best_q) begin
          best_d     = scan_val;
          best_id_d  = scan_idx_q;
          scan_tie_d = 1'b0;
        end else if (scan_val == best_q) begin
          scan_tie_d = 1'b1;
        end

        // The last neuron's comparison folds straight into the result.
        if (scan_idx_q == LAST_IDX) begin
          class_id_d    = best_id_d;
          class_count_d = best_d;
          tie_d         = scan_tie_d;
          state_d       = S_DONE;
        end else begin
          scan_idx_d = scan_idx_q + 1'b1;
        end
      end

      S_DONE: begin
        if (ack) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d  = (state_d == S_ACCUM) ||
              (state_d == S_SCAN);
    valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      step_q        <= '0;
      len_q         <= '0;
      scan_idx_q    <= '0;
      best_q        <= '0;
      best_id_q     <= '0;
      scan_tie_q    <= 1'b0;
      class_id_q    <= '0;
      class_count_q <= '0;
      tie_q         <= 1'b0;
      busy_q        <= 1'b0;
      valid_q       <= 1'b0;
      for (int i = 0; i < N_OUT; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      step_q        <= step_d;
      len_q         <= len_d;
      scan_idx_q    <= scan_idx_d;
      best_q        <= best_d;
      best_id_q     <= best_id_d;
      scan_tie_q    <= scan_tie_d;
      class_id_q    <= class_id_d;
      class_count_q <= class_count_d;
      tie_q         <= tie_d;
      busy_q        <= busy_d;
      valid_q       <= valid_d;
      for (int i = 0; i < N_OUT; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign busy        = busy_q;
  assign class_valid = valid_q;
  assign class_id    = class_id_q;
  assign class_count = class_count_q;
  assign tie         = tie_q;

endmodule

// File: tb/tb_spike_count_readout.sv
// tb_spike_count_readout: directed plus randomized windows against a
// count/max reference model; a second instance uses 4-bit counters.
module tb_spike_count_readout;

  localparam int N = 10;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [7:0]   window_len = '0;
  logic         ce = 1'b0;
  logic [N-1:0] spikes = '0;
  logic         ack = 1'b0;

  logic         busy, valid, tie;
  logic [3:0]   class_id;
  logic [7:0]   class_count;
  logic         busy4, valid4, tie4;
  logic [3:0]   class_id4;
  logic [3:0]   class_count4;

  int tests = 0;
  int fails = 0;
  logic [N-1:0] samp[$];
  int prev_id = 0, prev_cnt = 0, prev_tie = 0;
  int prev_id4 = 0, prev_cnt4 = 0, prev_tie4 = 0;

  spike_count_readout #(
    .N_OUT(10), .COUNT_BITS(8), .WINDOW_BITS(8)
  ) u_dut (
    .clk(clk), .reset(reset), .start(start),
    .window_len(window_len), .ce(ce),
    .spikes(spikes), .ack(ack), .busy(busy),
    .class_valid(valid), .class_id(class_id),
    .class_count(class_count), .tie(tie)
  );

  spike_count_readout #(
    .N_OUT(10), .COUNT_BITS(4), .WINDOW_BITS(8)
  ) u_dut4 (
    .clk(clk), .reset(reset), .start(start),
    .window_len(window_len), .ce(ce),
    .spikes(spikes), .ack(ack), .busy(busy4),
    .class_valid(valid4), .class_id(class_id4),
    .class_count(class_count4), .tie(tie4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Winner = highest saturated total, lowest index; tie if shared.
  task automatic model(input int maxv, output int eid,
                       output int ecnt, output int etie);
    int tot[N];
    int best, n;
    for (int i = 0; i < N; i++) tot[i] = 0;
    foreach (samp[j])
      for (int i = 0; i < N; i++)
        tot[i] += int'(samp[j][i]);
    for (int i = 0; i < N; i++)
      if (tot[i] > maxv) tot[i] = maxv;
    best = -1;
    eid = 0;
    for (int i = 0; i < N; i++)
      if (tot[i] > best) begin
        best = tot[i];
        eid = i;
      end
    n = 0;
    for (int i = 0; i < N; i++)
      if (tot[i] == best) n++;
    ecnt = best;
    etie = (n > 1) ? 1 : 0;
  endtask

  task automatic fill_rand(input int n,
                           input logic [N-1:0] force_m);
    samp.delete();
    for (int j = 0; j < n; j++)
      samp.push_back(N'($urandom) | force_m);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_id"}, class_id, 0);
    chk({tag, "_cnt"}, class_count, 0);
    chk({tag, "_tie"}, tie, 0);
    chk({tag, "_id4"}, class_id4, 0);
    chk({tag, "_cnt4"}, class_count4, 0);
  endtask

  // gapmode: 0 no ce gaps, 1 one gap per sample, 2 random gaps.
  task automatic run_window(input int len, input int gapmode,
                            input bit inj);
    int gaps, eid, ecnt, etie;
    start = 1'b1;
    window_len = 8'(len);
    tick();
    start = 1'b0;
    window_len = 8'($urandom);
    chk("start_busy", busy, 1);
    chk("start_valid", valid, 0);
    chk("hold_id", class_id, prev_id);
    chk("hold_cnt", class_count, prev_cnt);
    chk("hold_tie", tie, prev_tie);
    chk("hold_id4", class_id4, prev_id4);
    chk("hold_cnt4", class_count4, prev_cnt4);
    chk("hold_tie4", tie4, prev_tie4);
    foreach (samp[j]) begin
      gaps = (gapmode == 0) ? 0 :
             (gapmode == 1) ? 1 : int'($urandom_range(0, 2));
      repeat (gaps) begin
        ce = 1'b0;
        spikes = N'($urandom);
        start = inj ? 1'($urandom) : 1'b0;
        ack = inj ? 1'($urandom) : 1'b0;
        tick();
      end
      ce = 1'b1;
      spikes = samp[j];
      start = inj ? 1'($urandom) : 1'b0;
      ack = inj ? 1'($urandom) : 1'b0;
      tick();
    end
    ce = 1'b0;
    spikes = N'($urandom);
    for (int c = 1; c <= N; c++) begin
      start = inj && (c % 3 == 0);
      ack = inj && (c % 4 == 0);
      tick();
      if (c < N) begin
        chk("scan_busy", busy, 1);
        chk("scan_valid", valid, 0);
      end
    end
    start = 1'b0;
    ack = 1'b0;
    chk("done_valid", valid, 1);
    chk("done_busy", busy, 0);
    chk("done_valid4", valid4, 1);
    model(255, eid, ecnt, etie);
    chk("res_id", class_id, eid);
    chk("res_cnt", class_count, ecnt);
    chk("res_tie", tie, etie);
    prev_id = eid;
    prev_cnt = ecnt;
    prev_tie = etie;
    model(15, eid, ecnt, etie);
    chk("res_id4", class_id4, eid);
    chk("res_cnt4", class_count4, ecnt);
    chk("res_tie4", tie4, etie);
    prev_id4 = eid;
    prev_cnt4 = ecnt;
    prev_tie4 = etie;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("ack_valid", valid, 0);
    chk("ack_busy", busy, 0);
    chk("ack_hold_id", class_id, prev_id);
    chk("ack_hold_cnt", class_count, prev_cnt);
  endtask

  initial begin
    repeat (3) tick();
    chk_zero("reset");
    reset = 1'b0;
    tick();

    repeat (6) begin
      spikes = N'($urandom);
      ce = 1'($urandom);
      ack = 1'($urandom);
      tick();
      chk("idle_busy", busy, 0);
      chk("idle_valid", valid, 0);
    end
    ce = 1'b0;
    ack = 1'b0;

    samp.delete();
    for (int j = 0; j < 4; j++)
      samp.push_back((N'(1) << 3) |
                     ((j < 2) ? (N'(1) << 7) : N'(0)));
    run_window(4, 0, 1'b0);
    chk("basic_id", class_id, 3);
    chk("basic_cnt", class_count, 4);
    chk("basic_tie", tie, 0);
    repeat (5) begin
      tick();
      chk("stall_valid", valid, 1);
      chk("stall_id", class_id, 3);
      chk("stall_cnt", class_count, 4);
    end
    do_ack();

    samp.delete();
    repeat (3) samp.push_back(N'(10'b00_0010_0100));
    run_window(3, 0, 1'b0);
    chk("tie_id", class_id, 2);
    chk("tie_cnt", class_count, 3);
    chk("tie_tie", tie, 1);
    do_ack();

    samp.delete();
    repeat (2) samp.push_back('0);
    run_window(2, 2, 1'b0);
    chk("zero_id", class_id, 0);
    chk("zero_cnt", class_count, 0);
    chk("zero_tie", tie, 1);
    do_ack();

    fill_rand(1, N'(1) << 6);
    run_window(0, 0, 1'b0);
    do_ack();

    samp.delete();
    for (int j = 0; j < 255; j++)
      samp.push_back((N'(1) << 9) |
                     (N'($urandom & $urandom & $urandom)
                      & N'(10'h1ff)));
    run_window(255, 1, 1'b0);
    chk("sat_id", class_id, 9);
    chk("sat_cnt", class_count, 255);
    chk("sat_tie", tie, 0);
    chk("sat_cnt4", class_count4, 15);
    do_ack();

    fill_rand(6, '0);
    run_window(6, 2, 1'b1);
    do_ack();

    fill_rand(3, N'(1) << 1);
    run_window(3, 0, 1'b0);
    start = 1'b1;
    ack = 1'b1;
    window_len = 8'd5;
    tick();
    start = 1'b0;
    ack = 1'b0;
    chk("sa_busy", busy, 0);
    chk("sa_valid", valid, 0);
    tick();
    chk("sa_idle_busy", busy, 0);

    fill_rand(5, N'(1) << 4);
    start = 1'b1;
    window_len = 8'd5;
    tick();
    start = 1'b0;
    foreach (samp[j]) begin
      ce = 1'b1;
      spikes = samp[j];
      tick();
    end
    ce = 1'b0;
    repeat (4) tick();
    #2 reset = 1'b1;
    #1 chk_zero("async_rst");
    tick();
    tick();
    reset = 1'b0;
    repeat (15) begin
      tick();
      chk("abort_valid", valid, 0);
      chk("abort_busy", busy, 0);
    end
    prev_id = 0;
    prev_cnt = 0;
    prev_tie = 0;
    prev_id4 = 0;
    prev_cnt4 = 0;
    prev_tie4 = 0;

    fill_rand(7, '0);
    run_window(7, 2, 1'b1);
    do_ack();

    for (int k = 0; k < 6; k++) begin
      int len;
      len = int'($urandom_range(1, 20));
      fill_rand(len, '0);
      run_window(len, 2, 1'($urandom));
      repeat ($urandom_range(0, 3)) begin
        tick();
        chk("rand_stall", valid, 1);
      end
      do_ack();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spike_count_readout.md
# spike_count_readout

Downstream readout stage for the output layer of the spiking network. Over a programmable window of timesteps, it counts the spikes emitted by each of the N_OUT output neurons. At the end of the window it sequentially scans the per-neuron counts and reports the winning class index with a valid/ack handshake. It sits between the last neuron layer's `is_spike` outputs and the chip's `uo_out` pins.

## Interface
Parameters:
- N_OUT, 10, number of output neurons / classes
- COUNT_BITS, 8, width of each per-neuron spike counter (saturating)
- WINDOW_BITS, 8, width of the window-length field and timestep counter
- ID_BITS, $clog2(N_OUT), width of class index (4 for N_OUT=10)

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; clears all state and outputs
- start  in  1  begin a new classification window; accepted only in IDLE
- window_len  in  WINDOW_BITS  number of timesteps per window; sampled when start is accepted
- ce  in  1  timestep strobe; spikes are sampled only on cycles with ce=1 in ACCUM
- spikes  in  N_OUT  one spike bit per output neuron for the current timestep
- ack  in  1  consumer acknowledges the result; meaningful only while class_valid=1
- busy  out  1  1 in ACCUM or SCAN
- class_valid  out  1  result available; held until ack
- class_id  out  ID_BITS  index of the neuron with the highest count
- class_count  out  COUNT_BITS  spike count of the winner
- tie  out  1  another neuron's count equals the winner's count

## Operation
- FSM states: IDLE, ACCUM, SCAN, DONE. Reset puts the FSM in IDLE.
- IDLE: on start=1, go to ACCUM.
  - All N_OUT counters clear to 0.
  - Step counter clears to 0.
  - window_len latches; a value of 0 is treated as 1.
- ACCUM: on each edge with ce=1:
  - Every counter i with spikes[i]=1 increments.
  - A counter at 2^COUNT_BITS-1 holds at that value (saturates).
  - Step counter increments.
  - When the incremented step count equals the latched length, go to SCAN with scan index = 0.
  - ce=0 cycles change nothing.
- SCAN: one neuron per cycle, index 0..N_OUT-1.
  - Index 0: best ← cnt[0], best_id ← 0, tie ← 0.
  - Index i>0, cnt[i] > best: best ← cnt[i], best_id ← i, tie ← 0.
  - Index i>0, cnt[i] == best: tie ← 1; best_id is unchanged, so the lowest index wins.
  - After index N_OUT-1: register class_id, class_count and tie, then go to DONE.
- DONE: class_valid=1. On ack=1, go to IDLE and class_valid falls.
- Result outputs:
  - class_id, class_count and tie hold their values after ack until the next SCAN completes.
  - Scan-internal best/tie registers never drive the outputs directly.
- Ignored inputs:
  - start is ignored in ACCUM, SCAN and DONE, including start and ack in the same DONE cycle (return to IDLE; start is not accepted).
  - ack is ignored outside DONE.
  - spikes and ce are ignored outside ACCUM.
- All counts zero: class_id=0, class_count=0, tie=1.

## Timing
- Reset values:
  - busy=0, class_valid=0, class_id=0, class_count=0, tie=0.
  - All counters and the step counter are 0; the FSM is in IDLE.
- Reset asserted mid-window or mid-scan aborts immediately (asynchronously) to those values; no partial result is emitted.
- Start acceptance:
  - start sampled at edge k → busy=1 after edge k.
  - The first spike sample can occur at edge k+1.
- End of window:
  - The final accumulating ce edge is edge m.
  - SCAN occupies edges m+1 .. m+N_OUT.
  - class_valid=1 and busy=0 after edge m+N_OUT, i.e. N_OUT cycles after the last sample.
- Handshake:
  - ack sampled at edge d with class_valid=1 → class_valid=0 after edge d.
  - The earliest next start is accepted at edge d+1.
- Outputs are registered; there are no combinational paths from inputs to outputs.
- Throughput: minimum cycles per classification = 1 (start) + window_len + N_OUT + 1 (ack).

## Test plan
- Reset then idle:
  - Assert reset asynchronously between edges → all outputs are 0 immediately.
  - Toggle spikes/ce in IDLE → no state change; busy=0.
- Basic winner (N_OUT=10, window_len=4, ce every cycle):
  - Neuron 3 spikes on all 4 steps, neuron 7 on 2, others never.
  - Expect class_valid exactly 10 cycles after the 4th sample, class_id=3, class_count=4, tie=0.
  - Hold ack=0 for 5 cycles → outputs stable; then ack=1 → class_valid=0 next cycle.
- Tie and all-zero:
  - Neurons 2 and 5 each spike 3 times → class_id=2, class_count=3, tie=1.
  - Next window with no spikes → class_id=0, class_count=0, tie=1.
- Saturation and ce gating (COUNT_BITS=8):
  - window_len=0 (treated as 1) → a single sample is taken.
  - Then window_len=255 with ce active every other cycle and neuron 9 always spiking:
    - Exactly 255 samples are taken (510 cycles).
    - Expect class_id=9, class_count=255, tie=0.
  - Reduce COUNT_BITS to 4 in the same window → count saturates at 15.
- Ignored start / simultaneous events:
  - Pulse start during ACCUM and SCAN → window is not restarted; counts are unaffected.
  - In DONE, assert start and ack together → returns to IDLE, not ACCUM.
- Reset mid-operation:
  - Assert reset in the middle of the scan → class_valid never rises.
  - Deassert reset, start a new window → the result reflects only the new spikes.
